fp_to_pcm: RTL and testbench

//  Converts the IEEE-754 single-precision result of the FP multiplier (gain stage) into a signed PCM sample.

---
 rtl/fp_to_pcm.sv | 181 ++++++++++++++++++
 tb/tb_fp_to_pcm.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fp_to_pcm.sv
// fp_to_pcm: converts an IEEE-754 single-precision gain-stage result into a
// signed PCM sample. The input range [-1.0, 1.0) maps to full-scale PCM. The
// result is rounded half away from zero and saturated. The mantissa is aligned
// by an iterative one-bit-per-clock right shift, so no barrel shifter is needed.
module fp_to_pcm #(
    parameter int unsigned PCM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [31:0]          in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [PCM_WIDTH-1:0] out_sample,
    output logic                 out_sat,
    output logic                 out_nan,
    output logic                 overrun
);

    localparam int unsigned MANT_W  = 24;
    localparam int unsigned CNT_W   = 5;
    localparam logic [7:0]  EXP_ONE = 8'd127;
    localparam logic [7:0]  EXP_INF = 8'hFF;
    // Smallest exponent that can still round to a nonzero LSB.
    localparam logic [7:0]  EXP_MIN = 8'(127 - PCM_WIDTH);
    // The shift count is (151 - W - e) - 1. The final bit is kept as the rounding bit.
    localparam logic [8:0]  CNT_BASE = 9'(150 - PCM_WIDTH);

    localparam logic [PCM_WIDTH-1:0] PCM_MAX = {1'b0, {(PCM_WIDTH-1){1'b1}}};
    localparam logic [PCM_WIDTH-1:0] PCM_MIN = {1'b1, {(PCM_WIDTH-1){1'b0}}};
    localparam logic [MANT_W-1:0]    MAG_MAX_POS = MANT_W'(PCM_MAX);
    localparam logic [MANT_W-1:0]    MAG_MAX_NEG = MANT_W'(PCM_MIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_SHIFT,
        S_ROUND,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [31:0]            r_data;
    logic [MANT_W-1:0]      r_shift;
    logic [CNT_W-1:0]       r_count;
    logic [PCM_WIDTH-1:0]   r_result;
    logic                   r_sat;
    logic                   r_nan;

    logic                   w_sign;
    logic [7:0]             w_exp;
    logic [22:0]            w_frac;
    logic                   w_is_nan;
    logic                   w_is_neg_one;
    logic                   w_is_big;
    logic                   w_is_tiny;
    logic [CNT_W-1:0]       w_count;
    logic [PCM_WIDTH-1:0]   w_clamp;
    logic [MANT_W-1:0]      w_mag;
    logic                   w_pos_sat;
    logic                   w_neg_sat;
    logic [PCM_WIDTH-1:0]   w_mag_pcm;
    logic [PCM_WIDTH-1:0]   w_neg_pcm;

    // Upstream may only present a sample while the converter is idle.
    assign in_ready = (r_state == S_IDLE);

    // Field split of the latched operand.
    assign w_sign = r_data[31];
    assign w_exp  = r_data[30:23];
    assign w_frac = r_data[22:0];

    // Classification used by DECODE.
    always_comb begin
        w_is_nan     = (w_exp == EXP_INF) && (w_frac != 23'd0);
        w_is_neg_one = w_sign && (w_exp == EXP_ONE) && (w_frac == 23'd0);
        w_is_big     = (w_exp == EXP_INF) || (w_exp >= EXP_ONE);
        w_is_tiny    = (w_exp == 8'd0) || (w_exp < EXP_MIN);
        w_count      = CNT_W'(CNT_BASE - {1'b0, w_exp});
        w_clamp      = w_sign ? PCM_MIN : PCM_MAX;
    end

    // Rounding: the LSB of the shift register is the half bit, and ties go away from zero.
    always_comb begin
        w_mag     = {1'b0, r_shift[MANT_W-1:1]} + {{(MANT_W-1){1'b0}}, r_shift[0]};
        w_pos_sat = (w_mag > MAG_MAX_POS);
        w_neg_sat = (w_mag > MAG_MAX_NEG);
        w_mag_pcm = PCM_WIDTH'(w_mag);
        w_neg_pcm = (w_mag == MAG_MAX_NEG) ? PCM_MIN : PCM_WIDTH'(MANT_W'(0) - w_mag);
    end

    // Conversion FSM with registered results and a sticky overrun flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_data     <= '0;
            r_shift    <= '0;
            r_count    <= '0;
            r_result   <= '0;
            r_sat      <= 1'b0;
            r_nan      <= 1'b0;
            out_valid  <= 1'b0;
            out_sample <= '0;
            out_sat    <= 1'b0;
            out_nan    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_valid <= 1'b0;

            if (in_valid && (r_state != S_IDLE)) begin
                overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_state <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    r_result <= '0;
                    r_sat    <= 1'b0;
                    r_nan    <= 1'b0;
                    if (w_is_nan) begin
                        r_nan   <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_is_neg_one) begin
                        r_result <= PCM_MIN;
                        r_state  <= S_DONE;
                    end else if (w_is_big) begin
                        r_result <= w_clamp;
                        r_sat    <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (w_is_tiny) begin
                        r_state <= S_DONE;
                    end else begin
                        r_shift <= {1'b1, w_frac};
                        r_count <= w_count;
                        r_state <= (w_count != '0) ? S_SHIFT : S_ROUND;
                    end
                end

                S_SHIFT: begin
                    r_shift <= r_shift >> 1;
                    r_count <= r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1)) begin
                        r_state <= S_ROUND;
                    end
                end

                S_ROUND: begin
                    if (!w_sign && w_pos_sat) begin
                        r_result <= PCM_MAX;
                        r_sat    <= 1'b1;
                    end else if (w_sign && w_neg_sat) begin
                        r_result <= PCM_MIN;
                        r_sat    <= 1'b1;
                    end else begin
                        r_result <= w_sign ? w_neg_pcm : w_mag_pcm;
                    end
                    r_state <= S_DONE;
                end

                S_DONE: begin
                    out_valid  <= 1'b1;
                    out_sample <= r_result;
                    out_sat    <= r_sat;
                    out_nan    <= r_nan;
                    r_state    <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_to_pcm.sv
// Directed bench for fp_to_pcm with PCM_WIDTH = 16. Expected samples are queued
// when the stimulus is driven. A monitor pops and compares each out_valid,
// including the accept-to-output latency.
module tb_fp_to_pcm;

    localparam int unsigned W = 16;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_data  = 32'd0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_sample;
    logic          out_sat;
    logic          out_nan;
    logic          overrun;

    typedef struct {
        logic [31:0]  din;
        logic [W-1:0] sample;
        logic         sat;
        logic         nan;
        int unsigned  acc;
        int unsigned  lat;
    } exp_t;

    exp_t        q[$];
    exp_t        e_mon;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_pushed = 0;
    int          n_seen   = 0;
    int unsigned cyc      = 0;

    fp_to_pcm #(.PCM_WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_sample (out_sample),
        .out_sat    (out_sat),
        .out_nan    (out_nan),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // Normal-path latency: r + 2, where r = 151 - W - e.
    function automatic int unsigned norm_lat(input int unsigned e);
        return 151 - W - e + 2;
    endfunction

    // Output monitor: every out_valid must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1) begin
            n_seen++;
            chk("out_valid_has_expectation", 32'(q.size()), 32'd1);
            if (q.size() != 0) begin
                e_mon = q.pop_front();
                chk($sformatf("sample[%08h]", e_mon.din), 32'(out_sample), 32'(e_mon.sample));
                chk($sformatf("sat[%08h]", e_mon.din), 32'(out_sat), 32'(e_mon.sat));
                chk($sformatf("nan[%08h]", e_mon.din), 32'(out_nan), 32'(e_mon.nan));
                chk($sformatf("latency[%08h]", e_mon.din), cyc - e_mon.acc, e_mon.lat);
            end
        end
    end

    task automatic send(input logic [31:0] d, input bit expect_out,
                        input logic [W-1:0] s, input logic sat, input logic nan,
                        input int unsigned lat);
        exp_t e;
        @(negedge clk);
        chk("in_ready_before_send", 32'(in_ready), 32'd1);
        in_data  = d;
        in_valid = 1'b1;
        if (expect_out) begin
            e.din = d; e.sample = s; e.sat = sat; e.nan = nan;
            e.acc = cyc + 1; e.lat = lat;
            q.push_back(e);
            n_pushed++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int unsigned budget);
        int unsigned k = 0;
        while (q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic conv(input logic [31:0] d, input logic [W-1:0] s,
                        input logic sat, input logic nan, input int unsigned lat);
        send(d, 1'b1, s, sat, nan, lat);
        wait_drain(60);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sample", 32'(out_sample), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_out_nan", 32'(out_nan), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;

        // Main conversions and boundaries
        conv(32'h3F000000, 16'h4000, 1'b0, 1'b0, norm_lat(126));
        conv(32'h3F7FFFFF, 16'h7FFF, 1'b1, 1'b0, norm_lat(126));
        conv(32'hBF800000, 16'h8000, 1'b0, 1'b0, 2);
        conv(32'h37800000, 16'h0001, 1'b0, 1'b0, 26);
        conv(32'hB7800000, 16'hFFFF, 1'b0, 1'b0, 26);
        conv(32'h37000000, 16'h0000, 1'b0, 1'b0, 2);
        conv(32'h7FC00000, 16'h0000, 1'b0, 1'b1, 2);
        conv(32'hFF800000, 16'h8000, 1'b1, 1'b0, 2);
        conv(32'hBF000000, 16'hC000, 1'b0, 1'b0, norm_lat(126));
        conv(32'h80000000, 16'h0000, 1'b0, 1'b0, 2);
        conv(32'h3FC00000, 16'h7FFF, 1'b1, 1'b0, 2);
        conv(32'h7F800000, 16'h7FFF, 1'b1, 1'b0, 2);
        conv(32'h38400000, 16'h0002, 1'b0, 1'b0, norm_lat(112));
        conv(32'hB8400000, 16'hFFFE, 1'b0, 1'b0, norm_lat(112));
        conv(32'h3E800000, 16'h2000, 1'b0, 1'b0, norm_lat(125));
        conv(32'h00400000, 16'h0000, 1'b0, 1'b0, 2);

        // Overrun: a second in_valid three cycles after acceptance is dropped
        chk("overrun_clear_before", 32'(overrun), 32'd0);
        @(negedge clk);
        chk("in_ready_before_ovr", 32'(in_ready), 32'd1);
        in_data  = 32'h3F000000;
        in_valid = 1'b1;
        q.push_back('{din: 32'h3F000000, sample: 16'h4000, sat: 1'b0, nan: 1'b0,
                      acc: cyc + 1, lat: norm_lat(126)});
        n_pushed++;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        in_data  = 32'h3E800000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("overrun_set", 32'(overrun), 32'd1);
        wait_drain(60);
        repeat (20) @(negedge clk);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        conv(32'hBF000000, 16'hC000, 1'b0, 1'b0, norm_lat(126));
        chk("overrun_sticky_after_conv", 32'(overrun), 32'd1);

        // Reset in the middle of SHIFT abandons the sample
        send(32'h37800000, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_sample", 32'(out_sample), 32'd0);
        chk("midrst_out_sat", 32'(out_sat), 32'd0);
        chk("midrst_out_nan", 32'(out_nan), 32'd0);
        chk("midrst_overrun", 32'(overrun), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (35) @(negedge clk);
        conv(32'h3E800000, 16'h2000, 1'b0, 1'b0, norm_lat(125));

        repeat (5) @(negedge clk);
        chk("out_valid_count", 32'(n_seen), 32'(n_pushed));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
